// File: rtl/llr_set_serializer.sv
// Parallel-to-serial LLR set streamer: one P*Q set in, P elements of Q bits out, sets counted per frame.
// Optional macro SERIALIZER_PREFETCH_EN adds a one-set holding register so consecutive sets stream with no gap.
`timescale 1ns/1ps

module llr_set_serializer #(
    parameter int unsigned Q    = 6,
    parameter int unsigned P    = 128,
    parameter int unsigned SETS = 8,
    parameter int unsigned SCW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [P*Q-1:0]   set_LLR,
    input  logic             set_valid,
    output logic             set_ready,
    output logic [Q-1:0]     out_LLR,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last_set,
    output logic             out_last_frame,
    output logic [SCW-1:0]   O_set_count
);

    localparam int unsigned W   = P * Q;
    localparam int unsigned ECW = $clog2(P);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     sbuf_q, sbuf_d;
    logic [ECW-1:0]   cnt_q, cnt_d;
    logic [SCW-1:0]   set_cnt_q, set_cnt_d;
`ifdef SERIALIZER_PREFETCH_EN
    logic [W-1:0]     hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
`endif

    logic accept;
    logic xfer;
    logic last_xfer;

    // Handshake decode, from registered state and the two input strobes
    always_comb begin
`ifdef SERIALIZER_PREFETCH_EN
        set_ready = !hold_full_q;
`else
        set_ready = (state_q == IDLE);
`endif
        out_valid      = (state_q == SHIFT);
        out_LLR        = sbuf_q[Q-1:0];
        out_last_set   = out_valid && (cnt_q == ECW'(P - 1));
        out_last_frame = out_last_set && (set_cnt_q == SCW'(SETS - 1));
        O_set_count    = set_cnt_q;
        accept         = set_valid && set_ready;
        xfer           = out_valid && out_ready;
        last_xfer      = xfer && (cnt_q == ECW'(P - 1));
    end

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sbuf_q      <= '0;
            cnt_q       <= '0;
            set_cnt_q   <= '0;
`ifdef SERIALIZER_PREFETCH_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sbuf_q      <= sbuf_d;
            cnt_q       <= cnt_d;
            set_cnt_q   <= set_cnt_d;
`ifdef SERIALIZER_PREFETCH_EN
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

    // Next-state: leave SHIFT only when the last element goes and nothing is queued behind it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
`ifdef SERIALIZER_PREFETCH_EN
                if (last_xfer && !hold_full_q && !accept) state_d = IDLE;
`else
                if (last_xfer) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        sbuf_d    = sbuf_q;
        cnt_d     = cnt_q;
        set_cnt_d = set_cnt_q;
`ifdef SERIALIZER_PREFETCH_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        if (state_q == IDLE) begin
            if (accept) begin
                sbuf_d = set_LLR;
                cnt_d  = '0;
            end
        end else if (xfer) begin
            sbuf_d = {Q'(0), sbuf_q[W-1:Q]};
            cnt_d  = cnt_q + ECW'(1);
            if (last_xfer) begin
                cnt_d     = '0;
                set_cnt_d = (set_cnt_q == SCW'(SETS - 1)) ? '0 : set_cnt_q + SCW'(1);
`ifdef SERIALIZER_PREFETCH_EN
                if (hold_full_q) begin
                    sbuf_d      = hold_q;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    sbuf_d = set_LLR;
                end
`endif
            end
        end
`ifdef SERIALIZER_PREFETCH_EN
        // A set arriving mid-stream parks in the holding register
        if ((state_q == SHIFT) && accept && !last_xfer) begin
            hold_d      = set_LLR;
            hold_full_d = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_llr_set_serializer.sv
// Scoreboard bench for llr_set_serializer: expected elements queued at issue, monitor compares on each transfer.
`timescale 1ns/1ps

module tb_llr_set_serializer;

    localparam int unsigned Q    = 6;
    localparam int unsigned P    = 128;
    localparam int unsigned SETS = 8;
    localparam int unsigned SCW  = 5;
    localparam int unsigned W    = P * Q;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic [W-1:0]   set_LLR   = '0;
    logic           set_valid = 1'b0;
    logic           set_ready;
    logic [Q-1:0]   out_LLR;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_last_set;
    logic           out_last_frame;
    logic [SCW-1:0] O_set_count;

    typedef struct packed {
        logic [Q-1:0]   llr;
        logic           last_set;
        logic           last_frame;
        logic [SCW-1:0] setc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp        = 0;
    int   n_err        = 0;
    int   exp_set      = 0;
    int   lf_pulses    = 0;
    bit   ready_toggle = 1'b0;

    always #5 clk = ~clk;

    llr_set_serializer #(.Q(Q), .P(P), .SETS(SETS), .SCW(SCW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_LLR        (set_LLR),
        .set_valid      (set_valid),
        .set_ready      (set_ready),
        .out_LLR        (out_LLR),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last_set   (out_last_set),
        .out_last_frame (out_last_frame),
        .O_set_count    (O_set_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mk_set(input int base);
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < int'(P); i++) d[i*Q +: Q] = Q'((i + base) % 64);
        return d;
    endfunction

    // Queue the expected element stream of one set
    task automatic push_set(input logic [W-1:0] d);
        exp_t e;
        for (int i = 0; i < int'(P); i++) begin
            e.llr        = d[i*Q +: Q];
            e.last_set   = (i == int'(P) - 1);
            e.last_frame = (i == int'(P) - 1) && (exp_set == int'(SETS) - 1);
            e.setc       = SCW'(exp_set);
            sb_q.push_back(e);
        end
        exp_set = (exp_set + 1) % int'(SETS);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_set(input logic [W-1:0] d);
        bit got;
        got = 1'b0;
        push_set(d);
        set_LLR   = d;
        set_valid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (set_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        set_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 3000; c++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb_q.delete();
        exp_set = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Sink ready pattern
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = ready_toggle ? ~out_ready : 1'b1;
        end
    end

    // Monitor: compare every transfer against the scoreboard, and stall stability
    initial begin
        exp_t        e;
        bit          stall_prev;
        logic [Q-1:0] prev_llr;
        stall_prev = 1'b0;
        prev_llr   = '0;
        forever begin
            @(negedge clk);
            if (stall_prev && rst_n) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_llr", 32'(out_LLR), 32'(prev_llr));
            end
            stall_prev = out_valid && !out_ready;
            prev_llr   = out_LLR;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_llr", 32'(out_LLR), 32'(e.llr));
                    check("last_set", 32'(out_last_set), 32'(e.last_set));
                    check("last_frame", 32'(out_last_frame), 32'(e.last_frame));
                    check("set_count", 32'(O_set_count), 32'(e.setc));
                end
                if (out_last_frame) lf_pulses++;
            end
        end
    end

    // Gap measurement for two sets offered back to back
    task automatic measure_pair();
        int run1, gap, run2;
        run1 = 0; gap = 0; run2 = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        while (out_valid && run1 < 600) begin
            run1++;
            if (run1 == 64) check("busy_set_ready", 32'(set_ready), 32'd0);
            @(negedge clk);
        end
        while (!out_valid && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        while (out_valid && run2 < 600) begin
            run2++;
            @(negedge clk);
        end
`ifdef SERIALIZER_PREFETCH_EN
        check("pair_run", 32'(run1), 32'd256);
`else
        check("pair_run1", 32'(run1), 32'd128);
        check("pair_gap", 32'(gap), 32'd1);
        check("pair_run2", 32'(run2), 32'd128);
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_set_ready", 32'(set_ready), 32'd1);
        check("rst_set_count", 32'(O_set_count), 32'd0);
        check("rst_out_llr", 32'(out_LLR), 32'd0);
        check("rst_last_set", 32'(out_last_set), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single set, sink always ready
        send_set(mk_set(0));
        drain();
        check("after_set_ready", 32'(set_ready), 32'd1);
        check("after_out_valid", 32'(out_valid), 32'd0);

        // Same set, sink ready toggling
        ready_toggle = 1'b1;
        send_set(mk_set(0));
        drain();
        ready_toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full frame of eight sets
        apply_reset();
        @(posedge clk); #1;
        lf_pulses = 0;
        for (int s = 0; s < int'(SETS); s++) send_set(mk_set(s));
        drain();
        check("frame_lf_pulses", 32'(lf_pulses), 32'd1);
        check("frame_wrap_count", 32'(O_set_count), 32'd0);

        // Reset in the middle of set 3, element 40
        for (int s = 0; s < 3; s++) send_set(mk_set(s));
        drain();
        send_set(mk_set(3));
        repeat (40) @(posedge clk);
        #1;
        check("mid_elem40", 32'(out_LLR), 32'd43);
        check("mid_set_count", 32'(O_set_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_set_count", 32'(O_set_count), 32'd0);
        sb_q.delete();
        exp_set = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_set(mk_set(5));
        drain();

        // Second set offered while the first streams
        fork
            measure_pair();
            begin
                send_set(mk_set(9));
                send_set(mk_set(33));
            end
        join
        @(posedge clk); #1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
